// File: rtl/microcode_sequencer_if.sv
// rtl/microcode_sequencer_if.sv - instruction issue handshake between front end and sequencer
//
// Signals:
//   instr        16-bit instruction word offered by the front end
//   instr_valid  instruction offered this cycle
//   instr_ready  sequencer can take an instruction this cycle
// Modports:
//   master  instruction source (front end / testbench)
//   slave   microcode_sequencer
interface microcode_sequencer_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - microcode sequencer: instruction latch, step index, ROM address, register enables
//
// Ports:
//   clock         rising-edge system clock
//   reset         synchronous active-high reset
//   instr_if      instruction handshake (slave side): instr, instr_valid, instr_ready
//   mc_addr       microcode ROM address {opcode, m1!=0, m2!=0, attached, step}
//   uc_end        microcode: last micro-op of the instruction
//   uc_branch     microcode branch condition: 00 none, 01 flag[0], 10 flag[1], 11 either
//   uc_wait       microcode: hold the step until mem_ready
//   uc_dst_in     load register selected by dst field
//   uc_src_in     load register selected by src field
//   uc_dst_out    drive register selected by dst field
//   uc_src_out    drive register selected by src field
//   flag          condition flags from ALU/bus
//   mem_ready     memory/IO completion
//   reg_in        register load enables (one bit per register)
//   reg_out       register drive enables (one bit per register)
//   busy          sequencer is running an instruction
//   step          current microcode step index
//   overflow_err  one-cycle pulse after a step overflow aborted the instruction
module microcode_sequencer #(
  parameter int STEP_W     = 4,
  parameter int OP_W       = 4,
  parameter int RSEL_W     = 3,
  parameter int BRANCH_OFS = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  microcode_sequencer_if.slave       instr_if,
  output logic [OP_W+3+STEP_W-1:0]   mc_addr,
  input  logic                       uc_end,
  input  logic [1:0]                 uc_branch,
  input  logic                       uc_wait,
  input  logic                       uc_dst_in,
  input  logic                       uc_src_in,
  input  logic                       uc_dst_out,
  input  logic                       uc_src_out,
  input  logic [1:0]                 flag,
  input  logic                       mem_ready,
  output logic [(2**RSEL_W)-1:0]     reg_in,
  output logic [(2**RSEL_W)-1:0]     reg_out,
  output logic                       busy,
  output logic [STEP_W-1:0]          step,
  output logic                       overflow_err
);

  localparam int NREG = 2 ** RSEL_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                ovf_q, ovf_d;

  // Only the instruction fields the sequencer actually consumes are latched.
  logic [OP_W-1:0]     op_q, op_d;
  logic                m1_nz_q, m1_nz_d;
  logic                m2_nz_q, m2_nz_d;
  logic                att_q, att_d;
  logic [RSEL_W-1:0]   dst_q, dst_d;
  logic [RSEL_W-1:0]   src_q, src_d;

  logic                branch_taken;
  logic [STEP_W:0]     inc;
  logic [STEP_W:0]     step_sum;
  logic                running;

  assign running = (state_q == RUN);

  always_comb begin
    branch_taken = 1'b0;
    case (uc_branch)
      2'b01:   branch_taken = flag[0];
      2'b10:   branch_taken = flag[1];
      2'b11:   branch_taken = flag[0] | flag[1];
      default: branch_taken = 1'b0;
    endcase
  end

  // One extra bit on the sum so the carry out of the step field is visible.
  assign inc      = branch_taken ? (STEP_W+1)'(BRANCH_OFS) : (STEP_W+1)'(1);
  assign step_sum = {1'b0, step_q} + inc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      ovf_q   <= 1'b0;
      op_q    <= '0;
      m1_nz_q <= 1'b0;
      m2_nz_q <= 1'b0;
      att_q   <= 1'b0;
      dst_q   <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ovf_q   <= ovf_d;
      op_q    <= op_d;
      m1_nz_q <= m1_nz_d;
      m2_nz_q <= m2_nz_d;
      att_q   <= att_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ovf_d   = 1'b0;
    op_d    = op_q;
    m1_nz_d = m1_nz_q;
    m2_nz_d = m2_nz_q;
    att_d   = att_q;
    dst_d   = dst_q;
    src_d   = src_q;

    case (state_q)
      IDLE: begin
        if (instr_if.instr_valid) begin
          op_d    = instr_if.instr[15 -: OP_W];
          m1_nz_d = |instr_if.instr[11:10];
          m2_nz_d = |instr_if.instr[9:8];
          att_d   = instr_if.instr[1];
          dst_d   = instr_if.instr[5 +: RSEL_W];
          src_d   = instr_if.instr[2 +: RSEL_W];
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (uc_end) begin
          // End beats a pending wait: the instruction is finished regardless.
          state_d = IDLE;
          step_d  = '0;
        end else if (uc_wait && !mem_ready) begin
          step_d = step_q;
        end else if (step_sum[STEP_W]) begin
          state_d = IDLE;
          step_d  = '0;
          ovf_d   = 1'b1;
        end else begin
          step_d = step_sum[STEP_W-1:0];
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Enables follow the microcode fields combinationally, so they stay up
  // through a wait stall and on the cycle that overflows.
  always_comb begin
    reg_in  = '0;
    reg_out = '0;
    for (int k = 0; k < NREG; k++) begin
      reg_in[k]  = running && ((uc_dst_in  && (dst_q == RSEL_W'(k))) ||
                               (uc_src_in  && (src_q == RSEL_W'(k))));
      reg_out[k] = running && ((uc_dst_out && (dst_q == RSEL_W'(k))) ||
                               (uc_src_out && (src_q == RSEL_W'(k))));
    end
  end

  assign instr_if.instr_ready = (state_q == IDLE);
  assign mc_addr              = {op_q, m1_nz_q, m2_nz_q, att_q, step_q};
  assign busy                 = running;
  assign step                 = step_q;
  assign overflow_err         = ovf_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - self-checking bench for microcode_sequencer against a behavioural model
module tb_microcode_sequencer;
  localparam int STEP_W     = 4;
  localparam int OP_W       = 4;
  localparam int RSEL_W     = 3;
  localparam int NREG       = 8;
  localparam int BRANCH_OFS = 8;
  localparam int STEP_MAX   = 15;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  microcode_sequencer_if ifc();

  logic                     uc_end, uc_wait, uc_dst_in, uc_src_in, uc_dst_out, uc_src_out;
  logic                     mem_ready;
  logic [1:0]               uc_branch, flag;
  logic [NREG-1:0]          reg_in, reg_out;
  logic                     busy, overflow_err;
  logic [STEP_W-1:0]        step;
  logic [OP_W+3+STEP_W-1:0] mc_addr;

  microcode_sequencer #(
    .STEP_W(STEP_W), .OP_W(OP_W), .RSEL_W(RSEL_W), .BRANCH_OFS(BRANCH_OFS)
  ) dut (
    .clock(clock), .reset(reset), .instr_if(ifc),
    .mc_addr(mc_addr), .uc_end(uc_end), .uc_branch(uc_branch), .uc_wait(uc_wait),
    .uc_dst_in(uc_dst_in), .uc_src_in(uc_src_in), .uc_dst_out(uc_dst_out), .uc_src_out(uc_src_out),
    .flag(flag), .mem_ready(mem_ready), .reg_in(reg_in), .reg_out(reg_out),
    .busy(busy), .step(step), .overflow_err(overflow_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: running flag, integer step, latched instruction word, pulse.
  bit          m_busy  = 0;
  int          m_step  = 0;
  logic [15:0] m_instr = '0;
  bit          m_ovf   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] exp_addr();
    int a;
    a = int'(m_instr[15:12]) * 128
      + ((m_instr[11:10] != 2'b00) ? 64 : 0)
      + ((m_instr[9:8]   != 2'b00) ? 32 : 0)
      + (m_instr[1] ? 16 : 0)
      + m_step;
    return 32'(a);
  endfunction

  function automatic logic [31:0] exp_en(input bit via_dst, input bit via_src);
    int r;
    r = 0;
    if (m_busy) begin
      if (via_dst) r = r | (1 << int'(m_instr[7:5]));
      if (via_src) r = r | (1 << int'(m_instr[4:2]));
    end
    return 32'(r);
  endfunction

  task automatic compare_all();
    check("instr_ready", 32'(ifc.instr_ready), 32'(!m_busy));
    check("busy", 32'(busy), 32'(m_busy));
    check("step", 32'(step), 32'(m_step));
    check("mc_addr", 32'(mc_addr), exp_addr());
    check("reg_in", 32'(reg_in), exp_en(uc_dst_in, uc_src_in));
    check("reg_out", 32'(reg_out), exp_en(uc_dst_out, uc_src_out));
    check("overflow_err", 32'(overflow_err), 32'(m_ovf));
  endtask

  task automatic model_next();
    bit taken;
    int nxt;
    if (reset) begin
      m_busy = 0; m_step = 0; m_instr = '0; m_ovf = 0;
      return;
    end
    m_ovf = 0;
    if (!m_busy) begin
      if (ifc.instr_valid) begin
        m_instr = ifc.instr; m_step = 0; m_busy = 1;
      end
    end else if (uc_end) begin
      m_busy = 0; m_step = 0;
    end else if (!(uc_wait && !mem_ready)) begin
      taken = (uc_branch == 2'b01 && flag[0]) || (uc_branch == 2'b10 && flag[1]) ||
              (uc_branch == 2'b11 && (flag != 2'b00));
      nxt = m_step + (taken ? BRANCH_OFS : 1);
      if (nxt > STEP_MAX) begin
        m_step = 0; m_busy = 0; m_ovf = 1;
      end else begin
        m_step = nxt;
      end
    end
  endtask

  // Compare at the falling edge, advance model, return just after the rising edge.
  task automatic tick();
    @(negedge clock);
    compare_all();
    model_next();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    ifc.instr = '0; ifc.instr_valid = 0;
    uc_end = 0; uc_wait = 0; uc_branch = 2'b00;
    uc_dst_in = 0; uc_src_in = 0; uc_dst_out = 0; uc_src_out = 0;
    flag = 2'b00; mem_ready = 0; reset = 0;
  endtask

  task automatic issue(input logic [15:0] w);
    ifc.instr = w; ifc.instr_valid = 1;
    tick();
    ifc.instr_valid = 0;
  endtask

  initial begin
    quiet();
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
    check("reset_mc_addr", 32'(mc_addr), 32'h0);
    check("reset_ready", 32'(ifc.instr_ready), 32'h1);

    // Accept and free-running step
    issue(16'h5A24);
    check("accept_busy", 32'(busy), 32'h1);
    check("accept_mc_addr", 32'(mc_addr), 32'h2E0);
    tick(); check("step_1", 32'(step), 32'd1);
    tick(); check("step_2", 32'(step), 32'd2);

    // Wait stall for three cycles, enables held; released on mem_ready
    uc_wait = 1; uc_dst_in = 1;
    for (int i = 0; i < 3; i++) tick();
    check("wait_hold_step", 32'(step), 32'd2);
    check("wait_hold_reg_in", 32'(reg_in), 32'h02);
    mem_ready = 1; tick();
    check("wait_release_step", 32'(step), 32'd3);
    quiet(); uc_end = 1; tick(); quiet();
    check("end_idle", 32'(busy), 32'h0);

    // Branch taken on flag[0]
    issue(16'h3044); tick(); tick();
    uc_branch = 2'b01; flag = 2'b01; tick();
    check("branch_taken", 32'(step), 32'd10);
    quiet(); uc_end = 1; tick(); quiet();

    // Branch not taken, then OR-condition taken
    issue(16'h3044); tick(); tick();
    uc_branch = 2'b01; flag = 2'b00; tick();
    check("branch_not_taken", 32'(step), 32'd3);
    uc_branch = 2'b11; flag = 2'b10; tick();
    check("branch_or_taken", 32'(step), 32'd11);
    quiet();

    // Register enable decode, dst=2 src=1
    uc_dst_in = 1; uc_src_out = 1; #1;
    check("reg_in_decode", 32'(reg_in), 32'h04);
    check("reg_out_decode", 32'(reg_out), 32'h02);
    quiet();

    // Step up to 15 then overflow on increment
    for (int i = 0; i < 4; i++) tick();
    check("step_15", 32'(step), 32'd15);
    tick();
    check("ovf_pulse", 32'(overflow_err), 32'h1);
    check("ovf_idle", 32'(busy), 32'h0);
    check("ovf_step", 32'(step), 32'h0);
    check("ovf_ready", 32'(ifc.instr_ready), 32'h1);
    tick();
    check("ovf_one_cycle", 32'(overflow_err), 32'h0);
    uc_dst_in = 1; uc_src_out = 1; #1;
    check("idle_reg_in", 32'(reg_in), 32'h0);
    check("idle_reg_out", 32'(reg_out), 32'h0);
    quiet();

    // End wins over a pending wait
    issue(16'hC7FE); tick();
    uc_end = 1; uc_wait = 1; mem_ready = 0; tick(); quiet();
    check("end_over_wait", 32'(busy), 32'h0);

    // Reset mid-run
    issue(16'h9F1C); tick(); tick();
    reset = 1; tick(); reset = 0;
    check("reset_run_busy", 32'(busy), 32'h0);
    check("reset_run_step", 32'(step), 32'h0);
    check("reset_run_addr", 32'(mc_addr), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 149) == 0);
      ifc.instr        = 16'($urandom);
      ifc.instr_valid  = $urandom_range(0, 1);
      uc_end           = ($urandom_range(0, 9) == 0);
      uc_wait          = ($urandom_range(0, 3) == 0);
      mem_ready        = $urandom_range(0, 1);
      uc_branch        = 2'($urandom_range(0, 3));
      flag             = 2'($urandom_range(0, 3));
      uc_dst_in        = $urandom_range(0, 1);
      uc_src_in        = $urandom_range(0, 1);
      uc_dst_out       = $urandom_range(0, 1);
      uc_src_out       = $urandom_range(0, 1);
      tick();
    end
    quiet();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
